// File: rtl/compl_pkg.sv
// Shared definitions for the CORDIC phase extractor: FSM states, datapath widths,
// the arctangent table and the 12-bit angle type used by the complex generator.
package compl_pkg;

    localparam int ITER = 14;
    localparam int ZW   = 16;
    localparam int DW   = 18;
    localparam int AW   = 12;
    localparam int KW   = 4;

    typedef logic [AW-1:0] angle_t;

    typedef enum logic {
        S_IDLE,
        S_ITER
    } state_e;

    // atan(2^-k) expressed with a full turn equal to 2^ZW
    localparam logic [ZW-1:0] ATAN_TABLE [0:ITER-1] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163,
        16'd81,   16'd41,   16'd20,   16'd10,   16'd5,   16'd3,   16'd1
    };

    // Round the accumulator to 12 bits; the half-LSB carry wraps 4095.5 to 0
    function automatic angle_t roundAngle(input logic [ZW-1:0] z);
        return z[ZW-1:ZW-AW] + angle_t'(z[ZW-AW-1]);
    endfunction

endpackage

// File: rtl/compl_phase_if.sv
// Start/ready handshake bundle of the phase extractor; the mag signal exists only
// when COMPL_PHASE_MAG_EN is defined.
interface compl_phase_if;
    import compl_pkg::*;

    logic signed [15:0] r;
    logic signed [15:0] i;
    logic               start;
    angle_t             angle;
`ifdef COMPL_PHASE_MAG_EN
    logic [15:0]        mag;
`endif
    logic               busy;
    logic               ready;

`ifdef COMPL_PHASE_MAG_EN
    modport master (output r, i, start, input angle, mag, busy, ready);
    modport slave  (input r, i, start, output angle, mag, busy, ready);
`else
    modport master (output r, i, start, input angle, busy, ready);
    modport slave  (input r, i, start, output angle, busy, ready);
`endif

endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational micro-rotation angle lookup: k -> atan(2^-k); indices past the
// table return zero.
module cordic_atan_rom
    import compl_pkg::*;
(
    input  logic [KW-1:0] k_i,
    output logic [ZW-1:0] atan_o
);

    always_comb begin
        atan_o = '0;
        if (k_i < KW'(ITER)) begin
            atan_o = ATAN_TABLE[k_i];
        end
    end

endmodule

// File: rtl/compl_phase.sv
// compl_phase: iterative CORDIC vectoring unit returning the 12-bit angle of (r, i).
// Gain-corrected magnitude output is built only when COMPL_PHASE_MAG_EN is defined.
module compl_phase
    import compl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    compl_phase_if.slave bus
);

    state_e               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic signed [DW-1:0] x_q, x_d, y_q, y_d;
    logic [ZW-1:0]        z_q, z_d;
    logic                 zero_q, zero_d;
    angle_t               angle_q, angle_d;
    logic                 ready_q, ready_d;

    logic [ZW-1:0]        atanK;
    logic signed [DW-1:0] rExt, iExt;
    logic signed [DW-1:0] xShift, yShift, xIter, yIter;
    logic [ZW-1:0]        zIter;

    cordic_atan_rom atanRom (
        .k_i    (k_q),
        .atan_o (atanK)
    );

    assign rExt = {{(DW-16){bus.r[15]}}, bus.r};
    assign iExt = {{(DW-16){bus.i[15]}}, bus.i};

    // One micro-rotation steering y towards zero; both updates use the old x and y
    always_comb begin
        xShift = x_q >>> k_q;
        yShift = y_q >>> k_q;
        if (!y_q[DW-1]) begin
            xIter = x_q + yShift;
            yIter = y_q - xShift;
            zIter = z_q + atanK;
        end else begin
            xIter = x_q - yShift;
            yIter = y_q + xShift;
            zIter = z_q - atanK;
        end
    end

`ifdef COMPL_PHASE_MAG_EN
    logic [15:0]        mag_q, mag_d, magSat;
    logic signed [DW:0] xWide, magFull;

    // x * 0.6074 cancels the accumulated CORDIC gain, clamped to the 16-bit range
    always_comb begin
        xWide   = {xIter[DW-1], xIter};
        magFull = (xWide >>> 1) + (xWide >>> 3) - (xWide >>> 6) - (xWide >>> 9);
        magSat  = magFull[15:0];
        if (magFull[DW]) begin
            magSat = '0;
        end else if (|magFull[DW-1:16]) begin
            magSat = '1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        angle_d = angle_q;
        ready_d = 1'b0;
`ifdef COMPL_PHASE_MAG_EN
        mag_d   = mag_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ITER;
                    k_d     = '0;
                    zero_d  = (bus.r == '0) && (bus.i == '0);
                    // Left half-plane samples are pre-rotated by half a turn
                    if (rExt[DW-1]) begin
                        x_d = -rExt;
                        y_d = -iExt;
                        z_d = 16'h8000;
                    end else begin
                        x_d = rExt;
                        y_d = iExt;
                        z_d = '0;
                    end
                end
            end
            S_ITER: begin
                x_d = xIter;
                y_d = yIter;
                z_d = zIter;
                k_d = k_q + 1'b1;
                if (k_q == KW'(ITER-1)) begin
                    state_d = S_IDLE;
                    k_d     = '0;
                    ready_d = 1'b1;
                    angle_d = zero_q ? '0 : roundAngle(zIter);
`ifdef COMPL_PHASE_MAG_EN
                    mag_d   = zero_q ? '0 : magSat;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            ready_q <= ready_d;
        end
    end

`ifdef COMPL_PHASE_MAG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag_q <= '0;
        end else begin
            mag_q <= mag_d;
        end
    end

    assign bus.mag = mag_q;
`endif

    assign bus.angle = angle_q;
    assign bus.busy  = (state_q == S_ITER);
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_compl_phase.sv
// Self-checking bench for compl_phase: directed vector table plus handshake, overlap
// and mid-request reset sequences; mag checks are built with COMPL_PHASE_MAG_EN.
module tb_compl_phase;
    import compl_pkg::*;

    typedef struct {
        logic signed [15:0] r;
        logic signed [15:0] i;
        int                 angle;
        int                 angleTol;
        int                 mag;
        int                 magTol;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    compl_phase_if bus ();

    compl_phase dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Compares with a tolerance; wrap selects modulo-4096 distance for angles
    task automatic checkOutput(input string name, input int actual, input int expected,
                               input int tol, input bit wrap);
        int d;
        d = actual - expected;
        if (wrap) begin
            d = ((d % 4096) + 4096) % 4096;
            if (d > 2048) d = d - 4096;
        end
        if (d < 0) d = -d;
        checks++;
        if (d <= tol) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (tolerance %0d)", name, actual, expected, tol);
        end
    endtask

    // Presents a sample with start for one cycle; returns just after the start edge
    task automatic applyStimulus(input logic signed [15:0] rv, input logic signed [15:0] iv);
        bus.r     = rv;
        bus.i     = iv;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.r     = 16'sh5A5A;
        bus.i     = -16'sd1234;
    endtask

    // Counts clocks since the start edge until ready, bounded
    task automatic waitReady(input int already, output int lat);
        lat = already;
        while (bus.ready !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic countReadies(input int cycles, output int seen);
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) seen++;
        end
    endtask

    vec_t vecs [8];

    initial begin
        int lat;
        int seen;

        // Third-quadrant diagonal sits at 225 degrees, i.e. 2560 counts
        vecs[0] = '{16'sd16384,  16'sd0,      0,    1, 16384, 8};
        vecs[1] = '{16'sd0,      16'sd16384,  1024, 1, 16384, 8};
        vecs[2] = '{-16'sd16384, 16'sd0,      2048, 1, 16384, 8};
        vecs[3] = '{16'sd0,      -16'sd16384, 3072, 1, 16384, 8};
        vecs[4] = '{16'sd11585,  16'sd11585,  512,  1, 16384, 8};
        vecs[5] = '{16'sh8000,   16'sh8000,   2560, 1, 46341, 16};
        vecs[6] = '{16'sd32767,  -16'sd1,     0,    1, -1,    0};
        vecs[7] = '{16'sd0,      16'sd0,      0,    0, 0,     0};

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.r     = '0;
        bus.i     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput($sformatf("idle cycle %0d busy/ready/angle", c),
                        int'({bus.busy, bus.ready, bus.angle}), 0, 0, 1'b0);
`ifdef COMPL_PHASE_MAG_EN
            checkOutput($sformatf("idle cycle %0d mag", c), int'(bus.mag), 0, 0, 1'b0);
`endif
        end

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].r, vecs[v].i);
            checkOutput($sformatf("vec%0d busy after start", v), int'(bus.busy), 1, 0, 1'b0);
            waitReady(0, lat);
            checkOutput($sformatf("vec%0d latency", v), lat, 14, 0, 1'b0);
            checkOutput($sformatf("vec%0d angle", v), int'(bus.angle), vecs[v].angle,
                        vecs[v].angleTol, 1'b1);
`ifdef COMPL_PHASE_MAG_EN
            if (vecs[v].mag >= 0) begin
                checkOutput($sformatf("vec%0d mag", v), int'(bus.mag), vecs[v].mag,
                            vecs[v].magTol, 1'b0);
            end
`endif
            @(negedge clk);
            checkOutput($sformatf("vec%0d ready width", v), int'(bus.ready), 0, 0, 1'b0);
            checkOutput($sformatf("vec%0d busy after done", v), int'(bus.busy), 0, 0, 1'b0);
        end

        // Second start five cycles into a request must be ignored
        applyStimulus(16'sd0, 16'sd16384);
        lat = 0;
        repeat (5) begin
            @(negedge clk);
            lat++;
        end
        bus.r     = -16'sd16384;
        bus.i     = 16'sd0;
        bus.start = 1'b1;
        @(negedge clk);
        lat++;
        bus.start = 1'b0;
        waitReady(lat, lat);
        checkOutput("ignored start latency", lat, 14, 0, 1'b0);
        checkOutput("ignored start angle", int'(bus.angle), 1024, 1, 1'b1);
        countReadies(20, seen);
        checkOutput("ignored start extra ready", seen, 0, 0, 1'b0);
        checkOutput("ignored start angle held", int'(bus.angle), 1024, 1, 1'b1);

        // Start issued in the ready cycle launches the next request
        applyStimulus(16'sd16384, 16'sd0);
        waitReady(0, lat);
        checkOutput("first of pair angle", int'(bus.angle), 0, 1, 1'b1);
        applyStimulus(16'sd0, -16'sd16384);
        checkOutput("second of pair busy", int'(bus.busy), 1, 0, 1'b0);
        checkOutput("first result held", int'(bus.angle), 0, 1, 1'b1);
        waitReady(0, lat);
        checkOutput("second of pair latency", lat, 14, 0, 1'b0);
        checkOutput("second of pair angle", int'(bus.angle), 3072, 1, 1'b1);
        @(negedge clk);

        // Asynchronous reset seven iterations in aborts the request
        applyStimulus(16'sd11585, 16'sd11585);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort angle", int'(bus.angle), 0, 0, 1'b0);
        checkOutput("abort busy", int'(bus.busy), 0, 0, 1'b0);
        checkOutput("abort ready", int'(bus.ready), 0, 0, 1'b0);
`ifdef COMPL_PHASE_MAG_EN
        checkOutput("abort mag", int'(bus.mag), 0, 0, 1'b0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;
        countReadies(20, seen);
        checkOutput("abort no ready", seen, 0, 0, 1'b0);
        applyStimulus(16'sd0, 16'sd16384);
        waitReady(0, lat);
        checkOutput("post-abort latency", lat, 14, 0, 1'b0);
        checkOutput("post-abort angle", int'(bus.angle), 1024, 1, 1'b1);
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
